fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL take parameter RESET_PC, default 16'h0000, meaning the PC loaded on reset.
REQ-002 The module SHALL take parameter NOP_INSTR, default 16'h0800, meaning the instr value presented while no fetched instruction is held.
REQ-003 The module SHALL have one clock, clk, and one reset, rst; rst is synchronous and active-high.
REQ-004 The module SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction memory read request
- imem_addr  out  16  instruction memory byte address
- imem_rdata  in  16  instruction memory read data
- imem_done  in  1  read data valid this cycle
- instr  out  16  instruction word to decode
- pc_plus2  out  16  PC+2 of the held instruction
- instr_valid  out  1  instr holds a fetched instruction
- instr_ack  in  1  downstream has completed the held instruction
- redirect  in  1  branch/jump taken, qualified by instr_ack
- redirect_pc  in  16  target address
- halt  in  1  held instruction is HALT, qualified by instr_ack
- halted  out  1  fetch stopped
- retired  out  16  count of acknowledged instructions

Function
REQ-005 The module SHALL implement three states: FETCH, HOLD and HALTED.
REQ-006 In FETCH the module SHALL drive imem_req=1 and imem_addr=pc, and SHALL drive instr_valid=0.
REQ-007 In FETCH with imem_done=1, including the first FETCH cycle, the module SHALL capture imem_rdata into instr and enter HOLD next cycle.
REQ-008 In FETCH with imem_done=0, the module SHALL remain in FETCH with pc unchanged for an unbounded number of cycles.
REQ-009 In HOLD the module SHALL drive instr_valid=1 and imem_req=0, and SHALL hold instr stable until acknowledged.
REQ-010 In HOLD with instr_ack=1, the module SHALL increment retired by 1, which wraps at 16'hFFFF->0.
REQ-011 In HOLD with instr_ack=1, the module SHALL then select the next state by priority: halt -> HALTED with pc unchanged; else redirect -> pc<={redirect_pc[15:1],1'b0} then FETCH; else pc<=pc+2 then FETCH.
REQ-012 The module SHALL compute pc+2 modulo 2^16, so 16'hFFFE wraps to 16'h0000.
REQ-013 The module SHALL drive pc_plus2 combinationally as pc+2 at all times.
REQ-014 The module SHALL ignore halt, redirect and redirect_pc unless it is in HOLD with instr_ack=1.
REQ-015 The module SHALL ignore instr_ack outside HOLD.
REQ-016 The module SHALL ignore imem_done outside FETCH.
REQ-017 HALTED SHALL be terminal until rst: halted=1, imem_req=0, instr_valid=0, with instr and pc frozen.
REQ-018 The minimum throughput SHALL be 2 cycles per instruction (done in the first FETCH cycle, ack in the first HOLD cycle).
REQ-019 The module SHALL drive imem_addr[0]=0 always.

Reset
REQ-020 When rst=1 at a clock edge, the module SHALL set state=FETCH, pc=RESET_PC, instr=NOP_INSTR and retired=0.
REQ-021 With rst=1 at a clock edge, the outputs SHALL take these values next cycle: halted=0, instr_valid=0, imem_req=1, imem_addr=RESET_PC.
REQ-022 Reset SHALL override all other inputs, including in HALTED and in mid-wait.
REQ-023 Reset SHALL discard an imem_done arriving in the same cycle as rst.

Verification
REQ-024 The bench SHALL cover straight-line fetch: imem_done in the first FETCH cycle and ack in the first HOLD cycle, 3 times -> addresses 0000, 0002, 0004; instr_valid toggles every cycle; retired=3.
REQ-025 The bench SHALL cover wait states: imem_done delayed 4 cycles -> imem_req held 5 cycles at a fixed address; instr captured only on the done cycle.
REQ-026 The bench SHALL cover redirect: ack with redirect=1, redirect_pc=16'h0131 -> next imem_addr=16'h0130.
REQ-027 The bench SHALL cover ignored inputs: redirect=1 or halt=1 while in FETCH -> no effect.
REQ-028 The bench SHALL cover halt: ack with halt=1 and redirect=1 -> halted=1, imem_req=0 for 10+ cycles, pc unchanged, retired incremented once.
REQ-029 The bench SHALL cover wrap and reset: pc=16'hFFFE acked -> imem_addr=16'h0000; then rst during FETCH with imem_done=1 -> instr=16'h0800, retired=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction memory read port plus decode-side handshake.
// Master is the fetch stage, slave is memory/decode (or a bench).
interface fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        instr_ack;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output imem_req, imem_addr, instr, pc_plus2,
    output instr_valid, halted, retired,
    input  imem_rdata, imem_done, instr_ack,
    input  redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_plus2,
    input  instr_valid, halted, retired,
    output imem_rdata, imem_done, instr_ack,
    output redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: reads one instruction, holds it until decode acks,
// then steps, redirects or halts.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] retired_q;
  logic        take;
  logic        capture;

  assign capture = (state == FETCH) && bus.imem_done;
  assign take    = (state == HOLD) && bus.instr_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:   if (bus.imem_done) nxt = HOLD;
      HOLD:    if (bus.instr_ack) nxt = bus.halt ? HALTED : FETCH;
      HALTED:  nxt = HALTED;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= 16'd0;
    end else begin
      if (capture) instr_q <= bus.imem_rdata;
      if (take) begin
        retired_q <= retired_q + 16'd1;
        // halt keeps pc so the halted address stays observable
        if (!bus.halt) begin
          if (bus.redirect) pc <= bus.redirect_pc & 16'hFFFE;
          else              pc <= pc + 16'd2;
        end
      end
    end
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    unique case (state)
      FETCH:   bus.imem_req    = 1'b1;
      HOLD:    bus.instr_valid = 1'b1;
      HALTED:  bus.halted      = 1'b1;
      default: bus.imem_req    = 1'b0;
    endcase
  end

  assign bus.imem_addr = {pc[15:1], 1'b0};
  assign bus.pc_plus2  = pc + 16'd2;
  assign bus.instr     = instr_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic,
// all checked against a behavioural model every cycle.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic mvalid = 1'b0;

  // behavioural model of the fetch stage
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ret;
  logic        m_holding;
  logic        m_stopped;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc      = 16'h0000;
      m_instr   = 16'h0800;
      m_ret     = 16'h0000;
      m_holding = 1'b0;
      m_stopped = 1'b0;
      mvalid    = 1'b1;
    end else if (mvalid && !m_stopped) begin
      if (!m_holding) begin
        if (bus.imem_done) begin
          m_instr   = bus.imem_rdata;
          m_holding = 1'b1;
        end
      end else if (bus.instr_ack) begin
        m_ret     = m_ret + 16'd1;
        m_holding = 1'b0;
        if (bus.halt)          m_stopped = 1'b1;
        else if (bus.redirect) m_pc = bus.redirect_pc & 16'hFFFE;
        else                   m_pc = m_pc + 16'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_req", {15'd0, bus.imem_req},
          {15'd0, !m_holding && !m_stopped});
      chk("m_valid", {15'd0, bus.instr_valid}, {15'd0, m_holding});
      chk("m_halted", {15'd0, bus.halted}, {15'd0, m_stopped});
      chk("m_addr", bus.imem_addr, m_pc);
      chk("m_pc2", bus.pc_plus2, m_pc + 16'd2);
      chk("m_instr", bus.instr, m_instr);
      chk("m_ret", bus.retired, m_ret);
    end
  end

  task automatic step(input logic d, input logic [15:0] rd,
                      input logic a, input logic r,
                      input logic [15:0] rp, input logic h,
                      input logic rs);
    bus.imem_done   = d;
    bus.imem_rdata  = rd;
    bus.instr_ack   = a;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    bus.halt        = h;
    rst             = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a0;
    logic [15:0] r0;
    bus.imem_done   = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.instr_ack   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0;
    bus.halt        = 1'b0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd1);
    chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_instr", bus.instr, 16'h0800);
    chk("rst_ret", bus.retired, 16'h0000);

    // straight-line, 2 cycles per instruction
    for (int i = 0; i < 3; i++) begin
      chk("sl_addr", bus.imem_addr, 16'(2 * i));
      step(1, 16'hA000 + 16'(i), 0, 0, 0, 0, 0);
      chk("sl_valid", {15'd0, bus.instr_valid}, 16'd1);
      chk("sl_instr", bus.instr, 16'hA000 + 16'(i));
      step(0, 0, 1, 0, 0, 0, 0);
      chk("sl_valid0", {15'd0, bus.instr_valid}, 16'd0);
    end
    chk("sl_ret", bus.retired, 16'd3);
    chk("sl_next", bus.imem_addr, 16'h0006);

    // wait states: done on the fifth request cycle
    for (int i = 0; i < 4; i++) begin
      chk("ws_req", {15'd0, bus.imem_req}, 16'd1);
      chk("ws_addr", bus.imem_addr, 16'h0006);
      step(0, 16'hDEAD, 1, 1, 16'h4444, 1, 0);
      chk("ws_instr", bus.instr, 16'hA002);
    end
    chk("ws_req5", {15'd0, bus.imem_req}, 16'd1);
    step(1, 16'hB006, 0, 0, 0, 0, 0);
    chk("ws_cap", bus.instr, 16'hB006);

    // redirect clears bit 0
    step(0, 0, 1, 1, 16'h0131, 0, 0);
    chk("rd_addr", bus.imem_addr, 16'h0130);
    chk("rd_ret", bus.retired, 16'd4);

    // redirect/halt in FETCH ignored
    step(0, 0, 0, 1, 16'h7770, 1, 0);
    chk("ig_addr", bus.imem_addr, 16'h0130);
    chk("ig_halted", {15'd0, bus.halted}, 16'd0);

    // wrap at FFFE
    step(1, 16'hC130, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 16'hFFFF, 0, 0);
    chk("wr_fffe", bus.imem_addr, 16'hFFFE);
    chk("wr_pc2", bus.pc_plus2, 16'h0000);
    step(1, 16'hCFFE, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("wr_addr", bus.imem_addr, 16'h0000);

    // reset during FETCH with done asserted
    step(1, 16'hEEEE, 0, 0, 0, 0, 1);
    chk("rf_instr", bus.instr, 16'h0800);
    chk("rf_ret", bus.retired, 16'd0);
    chk("rf_addr", bus.imem_addr, 16'h0000);
    chk("rf_valid", {15'd0, bus.instr_valid}, 16'd0);

    // halt wins over redirect
    step(1, 16'h1111, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 16'h0500, 1, 0);
    for (int i = 0; i < 12; i++) begin
      chk("ht_halted", {15'd0, bus.halted}, 16'd1);
      chk("ht_req", {15'd0, bus.imem_req}, 16'd0);
      chk("ht_addr", bus.imem_addr, 16'h0002);
      chk("ht_ret", bus.retired, 16'd2);
      step(1, 16'h9999, 1, 1, 16'h0700, 1, 0);
    end
    chk("ht_instr", bus.instr, 16'h2222);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ht_rst", {15'd0, bus.halted}, 16'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      a0 = 16'($urandom);
      r0 = 16'($urandom);
      step(1'($urandom_range(0, 1)), a0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, r0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
